// File: rtl/intpol2_d4_out_fifo.sv
// intpol2_d4_out_fifo: DEPTH x DATA_WIDTH output FIFO, registered 1-cycle read.
// Define INTPOL2_FIFO_ERR_FLAGS_EN for sticky overflow/underflow flags.
module intpol2_d4_out_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 7,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  afull,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_FULL =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_AFULL =
    (ADDR_WIDTH+1)'(DEPTH - AFULL_MARGIN);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [ADDR_WIDTH:0]   count_nxt;

  // Flags are registered, so acceptance never sees same-cycle requests.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    count_nxt = count;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && wr_acc)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      empty    <= 1'b1;
      full     <= 1'b0;
      afull    <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      empty    <= 1'b1;
      full     <= 1'b0;
      afull    <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      rd_valid <= rd_acc;
      count    <= count_nxt;
      empty    <= (count_nxt == '0);
      full     <= (count_nxt == CNT_FULL);
      afull    <= (count_nxt >= CNT_AFULL);
    end
  end

`ifdef INTPOL2_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)
        overflow <= 1'b1;
      if (rd_en && empty)
        underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: doc/intpol2_d4_out_fifo.md
INTPOL2_D4_OUT_FIFO -- requirements
Module: intpol2_D4_out_fifo

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of stored samples (matches the interpolator datapath output).
REQ-002 Parameter ADDR_WIDTH, 7, log2 of depth; DEPTH = 2^ADDR_WIDTH = 128.
REQ-003 Parameter AFULL_MARGIN, 4, free-slot margin at which afull asserts; legal range 1..DEPTH-1.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 clear  input  1  synchronous flush, driven by the interpolator control path clear.
REQ-007 wr_en  input  1  write request, driven by the control path Write_Enable.
REQ-008 wr_data  input  DATA_WIDTH  sample to store.
REQ-009 rd_en  input  1  read request from the downstream consumer.
REQ-010 rd_data  output  DATA_WIDTH  registered read data.
REQ-011 rd_valid  output  1  rd_data holds a newly read word this cycle.
REQ-012 empty  output  1  count == 0.
REQ-013 full  output  1  count == DEPTH.
REQ-014 afull  output  1  count >= DEPTH-AFULL_MARGIN; feeds control path Afull_i.
REQ-015 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-016 overflow  output  1  sticky: write attempted while full (macro-gated).
REQ-017 underflow  output  1  sticky: read attempted while empty (macro-gated).

Function
REQ-018 Storage SHALL be DEPTH x DATA_WIDTH array with ADDR_WIDTH-bit write and read pointers wrapping modulo DEPTH.
REQ-019 Write accepted iff wr_en=1 and full=0 at the edge; word stored at wr_ptr, wr_ptr increments.
REQ-020 Read accepted iff rd_en=1 and empty=0 at the edge; rd_data <= mem[rd_ptr] next cycle, rd_ptr increments, rd_valid=1 that next cycle.
REQ-021 Read latency SHALL be exactly 1 cycle from accepted rd_en to rd_valid/rd_data; no first-word fall-through.
REQ-022 rd_data SHALL hold its last value when no read is accepted; rd_valid=0 in that cycle.
REQ-023 count: +1 on write-only, -1 on read-only, unchanged on both or neither accepted.
REQ-024 Full and rd_en+wr_en same cycle: read accepted, write rejected (word dropped), count becomes DEPTH-1.
REQ-025 Empty and rd_en+wr_en same cycle: write accepted, read rejected, rd_valid=0, count becomes 1.
REQ-026 empty, full, afull SHALL be registered, consistent with count after each edge (no combinational path from wr_en/rd_en).
REQ-027 Pointer wrap from DEPTH-1 to 0 SHALL occur with no lost or duplicated word.
REQ-028 clear=1 SHALL, at the edge, zero pointers, count, rd_valid, overflow, underflow; set empty=1, full=0, afull=0; override any wr_en/rd_en that cycle; rd_data unchanged.
REQ-029 Memory contents SHALL NOT be reset; only pointers/flags define validity.

Reset
REQ-030 On rst=1 at an edge: wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, empty=1, full=0, afull=0, overflow=0, underflow=0.
REQ-031 rst SHALL take priority over clear, wr_en, rd_en; reset mid-stream discards all stored words.

Configuration
REQ-032 Macro INTPOL2_FIFO_ERR_FLAGS_EN defined: overflow sets on any rejected write (wr_en=1, full=1), underflow on any rejected read (rd_en=1, empty=1); both sticky until rst or clear.
REQ-033 Macro undefined: overflow and underflow SHALL be tied to 0 with no flag registers; all other behaviour identical.

Verification
REQ-034 Reset, then write 128 words 0..127 -> afull rises after 124th write (count=124), full=1 after 128th, 129th write dropped, overflow=1 (macro on).
REQ-035 From full, read 128 words -> rd_data sequence 0..127 each 1 cycle after rd_en, empty=1 after last, extra rd_en gives rd_valid=0, underflow=1.
REQ-036 Continuous simultaneous rd_en/wr_en at count=3 for 300 cycles -> count stays 3, pointers wrap twice, output order matches input order.
REQ-037 count=128 with rd_en=wr_en=1 -> count=127, written word absent from later reads; count=0 with both -> count=1, rd_valid=0.
REQ-038 count=50, clear=1 with wr_en=1 -> count=0, empty=1, flags cleared, wr_data not stored; rst asserted at count=70 -> all REQ-030 values next cycle.
